sysver_reader: RTL and testbench

- AXI4-lite read-only master that sits directly upstream of the system version slave, on its S_AXI port.
- After reset, or on request, it reads the FPGA_VER register (offset 0x0) and the BOARD register (offset 0x4).
- It decodes both into fields and holds them stable on plain outputs for fabric consumers such as status LEDs, a debug UART or a housekeeping FSM, so no processor is needed to learn the build and board identity.
- Retries on error responses and flags timeouts.

---
 rtl/sysver_reader_if.sv | 24 ++
 rtl/sysver_reader.sv | 165 ++++++++++++++++
 tb/tb_sysver_reader.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysver_reader_if.sv
// rtl/sysver_reader_if.sv - AXI4-lite read-channel bundle between the version reader and its slave
interface sysver_reader_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arprot, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arprot, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/sysver_reader.sv
// rtl/sysver_reader.sv - AXI4-lite read master that snapshots FPGA_VER and BOARD into plain outputs
module sysver_reader #(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_BASE_ADDR        = 0,
    parameter int C_AUTO_START       = 1,
    parameter int C_TIMEOUT          = 255,
    parameter int C_MAX_RETRY        = 3,
    parameter int C_BOARD_TYPE_WIDTH = 4,
    parameter int C_BOARD_REV_WIDTH  = 4
) (
    input  logic                          m_axi_aclk,
    input  logic                          m_axi_areset,
    input  logic                          start,
    sysver_reader_if.master               m_axi,
    output logic [7:0]                    ver_maj,
    output logic [7:0]                    ver_min,
    output logic [15:0]                   ver_build,
    output logic [C_BOARD_TYPE_WIDTH-1:0] board_type,
    output logic [C_BOARD_REV_WIDTH-1:0]  board_rev,
    output logic                          info_valid,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [1:0]                    err_code
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int RW = $clog2(C_MAX_RETRY + 2);

    localparam logic [AW-1:0] ADDR_VER   = AW'(C_BASE_ADDR);
    localparam logic [AW-1:0] ADDR_BOARD = AW'(C_BASE_ADDR + 4);
    localparam logic [15:0]   TO_LAST    = 16'(C_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(C_MAX_RETRY);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, FAIL} state_t;

    state_t         state;
    logic           idx;
    logic [RW-1:0]  retry_cnt;
    logic [15:0]    tcnt;
    logic           tpend;
    logic           auto_armed;
    logic [31:0]    shadow_ver;
    logic           tmo_now;
    logic [1:0]     fail_code;

    assign m_axi.arprot = 3'b000;

    // A response is late if the flag is already up or the count reaches the limit on this very edge
    always_comb begin
        tmo_now = tpend || (tcnt == TO_LAST);
    end

    // Failure cause for the current response; timeout outranks whatever rresp says
    always_comb begin
        fail_code = 2'b01;
        if (tmo_now) begin
            fail_code = 2'b11;
        end else if (m_axi.rresp == 2'b11) begin
            fail_code = 2'b10;
        end
    end

    // Sequencer: issues the two reads, retries, and commits both fields to the outputs in one edge
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state          <= IDLE;
            idx            <= 1'b0;
            retry_cnt      <= '0;
            tcnt           <= '0;
            tpend          <= 1'b0;
            auto_armed     <= (C_AUTO_START != 0);
            shadow_ver     <= '0;
            m_axi.araddr   <= '0;
            m_axi.arvalid  <= 1'b0;
            m_axi.rready   <= 1'b0;
            ver_maj        <= '0;
            ver_min        <= '0;
            ver_build      <= '0;
            board_type     <= '0;
            board_rev      <= '0;
            info_valid     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_code       <= 2'b00;
        end else begin
            done <= 1'b0;
            if (state == ADDR || state == DATA) begin
                if (tcnt != 16'hFFFF) begin
                    tcnt <= tcnt + 16'd1;
                end
                if (tcnt == TO_LAST) begin
                    tpend <= 1'b1;
                end
            end
            case (state)
                IDLE, DONE, FAIL: begin
                    if (start || (state == IDLE && auto_armed)) begin
                        auto_armed    <= 1'b0;
                        state         <= ADDR;
                        idx           <= 1'b0;
                        retry_cnt     <= '0;
                        error         <= 1'b0;
                        err_code      <= 2'b00;
                        tcnt          <= '0;
                        tpend         <= 1'b0;
                        m_axi.arvalid <= 1'b1;
                        m_axi.araddr  <= ADDR_VER;
                        busy          <= 1'b1;
                    end
                end
                ADDR: begin
                    if (m_axi.arready) begin
                        state         <= DATA;
                        m_axi.arvalid <= 1'b0;
                        m_axi.rready  <= 1'b1;
                    end
                end
                DATA: begin
                    if (m_axi.rvalid) begin
                        m_axi.rready <= 1'b0;
                        if (m_axi.rresp == 2'b00 && !tmo_now) begin
                            if (!idx) begin
                                shadow_ver    <= m_axi.rdata[31:0];
                                idx           <= 1'b1;
                                state         <= ADDR;
                                m_axi.arvalid <= 1'b1;
                                m_axi.araddr  <= ADDR_BOARD;
                                tcnt          <= '0;
                                tpend         <= 1'b0;
                            end else begin
                                state      <= DONE;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                info_valid <= 1'b1;
                                ver_maj    <= shadow_ver[31:24];
                                ver_min    <= shadow_ver[23:16];
                                ver_build  <= shadow_ver[15:0];
                                board_type <= m_axi.rdata[16 +: C_BOARD_TYPE_WIDTH];
                                board_rev  <= m_axi.rdata[0 +: C_BOARD_REV_WIDTH];
                            end
                        end else begin
                            err_code <= fail_code;
                            if (retry_cnt < RETRY_MAX) begin
                                retry_cnt     <= retry_cnt + RW'(1);
                                state         <= ADDR;
                                m_axi.arvalid <= 1'b1;
                                m_axi.araddr  <= idx ? ADDR_BOARD : ADDR_VER;
                                tcnt          <= '0;
                                tpend         <= 1'b0;
                            end else begin
                                state      <= FAIL;
                                busy       <= 1'b0;
                                error      <= 1'b1;
                                info_valid <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sysver_reader.sv
// tb/tb_sysver_reader.sv - directed scoreboard bench for sysver_reader against a behavioural version slave
module tb_sysver_reader;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  ver_maj;
    logic [7:0]  ver_min;
    logic [15:0] ver_build;
    logic [3:0]  board_type;
    logic [3:0]  board_rev;
    logic        info_valid;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    sysver_reader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) axi ();

    sysver_reader dut (
        .m_axi_aclk   (clk),
        .m_axi_areset (rst),
        .start        (start),
        .m_axi        (axi),
        .ver_maj      (ver_maj),
        .ver_min      (ver_min),
        .ver_build    (ver_build),
        .board_type   (board_type),
        .board_rev    (board_rev),
        .info_valid   (info_valid),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // slave model state
    logic [31:0] ver_reg;
    logic [31:0] board_reg;
    int          stall_max = 0;
    int          r_fixed   = -1;
    bit          err_once  = 1'b0;
    int          sst       = 0;
    int          cnt       = 0;
    int          d         = 0;
    logic [3:0]  cap_addr;
    int          ar_hs     = 0;
    int          r_hs      = 0;
    int          done_cnt  = 0;
    logic [3:0]  exp_addr_q[$];
    logic [39:0] exp_snap_q[$];

    function automatic logic [31:0] mk_board(input logic [3:0] t, input logic [3:0] r);
        return {12'hABC, t, 12'h5A5, r};
    endfunction

    task automatic raise_r();
        axi.rdata = (cap_addr == 4'h4) ? board_reg : ver_reg;
        axi.rresp = 2'b00;
        if (err_once && cap_addr == 4'h0) begin
            axi.rresp = 2'b10;
            err_once  = 1'b0;
        end
        axi.rvalid = 1'b1;
        check("rready_with_rvalid", 64'(axi.rready), 64'(1));
        sst = 5;
    endtask

    // AXI4-lite version slave: random or fixed stalls, optional one-shot SLVERR
    initial begin
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (rst) begin
                axi.arready = 1'b0;
                axi.rvalid  = 1'b0;
                sst         = 0;
            end else begin
                case (sst)
                    1: begin
                        check("ar_stable", 64'({axi.arvalid, axi.araddr}), 64'({1'b1, cap_addr}));
                        cnt--;
                        if (cnt == 0) begin
                            axi.arready = 1'b1;
                            sst         = 2;
                        end
                    end
                    2: begin
                        axi.arready = 1'b0;
                        ar_hs++;
                        check("ar_expected", 64'(exp_addr_q.size() != 0), 64'(1));
                        if (exp_addr_q.size() != 0) begin
                            check("ar_addr", 64'(cap_addr), 64'(exp_addr_q.pop_front()));
                        end
                        d = (r_fixed >= 0) ? r_fixed : int'($urandom_range(0, stall_max));
                        if (d == 0) begin
                            raise_r();
                        end else begin
                            cnt = d;
                            sst = 3;
                        end
                    end
                    3: begin
                        cnt--;
                        if (cnt == 0) begin
                            raise_r();
                        end
                    end
                    5: begin
                        axi.rvalid = 1'b0;
                        r_hs++;
                        sst = 0;
                    end
                    default: ;
                endcase
                if (sst == 0 && axi.arvalid === 1'b1) begin
                    cap_addr = axi.araddr;
                    d = int'($urandom_range(0, stall_max));
                    if (d == 0) begin
                        axi.arready = 1'b1;
                        sst         = 2;
                    end else begin
                        cnt = d;
                        sst = 1;
                    end
                end
            end
        end
    end

    // Output monitor: each done pulse consumes one expected snapshot
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                check("snap_expected", 64'(exp_snap_q.size() != 0), 64'(1));
                if (exp_snap_q.size() != 0) begin
                    check("snapshot", 64'({ver_maj, ver_min, ver_build, board_type, board_rev}),
                          64'(exp_snap_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_seq(input string tag, input int budget);
        int n;
        bit ok;
        n = 0;
        while (busy !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n  = 0;
        ok = 1'b0;
        while (n < budget) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        check({tag, "_finished"}, 64'(ok), 64'(1));
        @(negedge clk);
    endtask

    task automatic push_reads(input logic [3:0] a, input logic [3:0] b);
        exp_addr_q.push_back(a);
        exp_addr_q.push_back(b);
    endtask

    int d0;
    int a0;
    int r0;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        ver_reg   = 32'h0205_0123;
        board_reg = mk_board(4'hA, 4'h3);
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({ver_maj, ver_min, ver_build, board_type, board_rev, info_valid, busy, done, error, err_code}),
              64'(0));
        check("reset_axi", 64'({axi.arvalid, axi.rready, axi.araddr}), 64'(0));
        check("arprot", 64'(axi.arprot), 64'(0));

        // 1: auto-start after reset, immediate slave
        push_reads(4'h0, 4'h4);
        exp_snap_q.push_back({8'h02, 8'h05, 16'h0123, 4'hA, 4'h3});
        d0 = done_cnt; a0 = ar_hs;
        #2 rst = 1'b0;
        wait_seq("s1", 100);
        check("s1_done_pulses", 64'(done_cnt - d0), 64'(1));
        check("s1_ar_count", 64'(ar_hs - a0), 64'(2));
        check("s1_status", 64'({info_valid, error, busy, err_code}), 64'({1'b1, 1'b0, 1'b0, 2'b00}));

        // 2: random stalls on both channels
        stall_max = 10;
        push_reads(4'h0, 4'h4);
        exp_snap_q.push_back({8'h02, 8'h05, 16'h0123, 4'hA, 4'h3});
        d0 = done_cnt; a0 = ar_hs;
        pulse_start();
        wait_seq("s2", 500);
        check("s2_done_pulses", 64'(done_cnt - d0), 64'(1));
        check("s2_ar_count", 64'(ar_hs - a0), 64'(2));
        check("s2_info_valid", 64'({info_valid, error}), 64'({1'b1, 1'b0}));
        stall_max = 0;

        // 3: one SLVERR on FPGA_VER then success
        err_once = 1'b1;
        exp_addr_q.push_back(4'h0);
        push_reads(4'h0, 4'h4);
        exp_snap_q.push_back({8'h02, 8'h05, 16'h0123, 4'hA, 4'h3});
        d0 = done_cnt; a0 = ar_hs;
        pulse_start();
        wait_seq("s3", 100);
        check("s3_err_code", 64'(err_code), 64'(2'b01));
        check("s3_status", 64'({info_valid, error}), 64'({1'b1, 1'b0}));
        check("s3_ar_count", 64'(ar_hs - a0), 64'(3));
        check("s3_done_pulses", 64'(done_cnt - d0), 64'(1));

        // 4: every response 300 cycles late -> four timed-out attempts, then FAIL
        r_fixed = 300;
        push_reads(4'h0, 4'h0);
        push_reads(4'h0, 4'h0);
        d0 = done_cnt; a0 = ar_hs; r0 = r_hs;
        pulse_start();
        wait_seq("s4", 3000);
        check("s4_status", 64'({error, err_code, info_valid, busy}), 64'({1'b1, 2'b11, 1'b0, 1'b0}));
        check("s4_ar_count", 64'(ar_hs - a0), 64'(4));
        check("s4_r_count", 64'(r_hs - r0), 64'(4));
        check("s4_no_done", 64'(done_cnt - d0), 64'(0));
        r_fixed = -1;

        // 5: refresh from DONE with new board pins; a second start mid-sequence is dropped
        push_reads(4'h0, 4'h4);
        exp_snap_q.push_back({8'h02, 8'h05, 16'h0123, 4'hA, 4'h3});
        pulse_start();
        wait_seq("s5a", 100);
        check("s5_recovered", 64'({info_valid, error, err_code}), 64'({1'b1, 1'b0, 2'b00}));
        board_reg = mk_board(4'h5, 4'h3);
        r_fixed   = 10;
        push_reads(4'h0, 4'h4);
        exp_snap_q.push_back({8'h02, 8'h05, 16'h0123, 4'h5, 4'h3});
        d0 = done_cnt; a0 = ar_hs;
        pulse_start();
        repeat (2) @(negedge clk);
        check("s5_busy", 64'(busy), 64'(1));
        check("s5_old_held", 64'({board_type, info_valid}), 64'({4'hA, 1'b1}));
        pulse_start();
        wait_seq("s5b", 200);
        check("s5_board_type", 64'(board_type), 64'(4'h5));
        check("s5_done_pulses", 64'(done_cnt - d0), 64'(1));
        repeat (20) @(negedge clk);
        check("s5_no_requeue", 64'({busy, 8'(ar_hs - a0)}), 64'({1'b0, 8'd2}));

        // 6: reset while DATA has rvalid pending, then auto-start re-reads
        r_fixed = 3;
        push_reads(4'h0, 4'h4);
        pulse_start();
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                #2;
                if (axi.rvalid === 1'b1 && axi.rready === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("s6_rvalid_pending", 64'(seen), 64'(1));
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("s6_axi_dropped", 64'({axi.arvalid, axi.rready}), 64'(0));
        check("s6_outputs_zero",
              64'({ver_maj, ver_min, ver_build, board_type, board_rev, info_valid, busy, done, error, err_code}),
              64'(0));
        exp_addr_q.delete();
        exp_snap_q.delete();
        r_fixed = -1;
        push_reads(4'h0, 4'h4);
        exp_snap_q.push_back({8'h02, 8'h05, 16'h0123, 4'h5, 4'h3});
        d0 = done_cnt; a0 = ar_hs;
        @(negedge clk);
        #2 rst = 1'b0;
        wait_seq("s6", 100);
        check("s6_done_pulses", 64'(done_cnt - d0), 64'(1));
        check("s6_ar_count", 64'(ar_hs - a0), 64'(2));
        check("s6_info_valid", 64'({info_valid, error}), 64'({1'b1, 1'b0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
